// File: rtl/ram_arb_pkg.sv
// Shared types and memory-map constants for the two-master RAM arbiter.
package ram_arb_pkg;

    typedef enum logic {
        PRIO_M0 = 1'b0,
        PRIO_M1 = 1'b1
    } arb_state_t;

    localparam int unsigned CONST_LAST   = 1207;
    localparam int unsigned BLOCK_LAST   = 1536;
    localparam int unsigned ROW_FIRST    = 2000;
    localparam int unsigned ROW_LAST     = 3024;

    localparam int unsigned STARVE_CNT_W = 4;

    // Holes in the map: between the block buffer and the row buffer, and above the row buffer.
    function automatic logic addr_out_of_map(input logic [31:0] addr);
        return ((addr > 32'(BLOCK_LAST)) && (addr < 32'(ROW_FIRST))) ||
               (addr > 32'(ROW_LAST));
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Per-master request/response bus of the RAM arbiter.
// With RAM_ARB_RANGE_CHECK_EN defined the bus also carries an error flag.
interface ram_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req;
    logic             we;
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] wdata;
    logic             gnt;
    logic             rvalid;
    logic [WIDTH-1:0] rdata;
`ifdef RAM_ARB_RANGE_CHECK_EN
    logic             err;

    modport master (output req, we, addr, wdata, input  gnt, rvalid, rdata, err);
    modport slave  (input  req, we, addr, wdata, output gnt, rvalid, rdata, err);
`else
    modport master (output req, we, addr, wdata, input  gnt, rvalid, rdata);
    modport slave  (input  req, we, addr, wdata, output gnt, rvalid, rdata);
`endif
endinterface

// File: rtl/ram_arb_resp.sv
// Per-master response register: one-cycle rvalid pulse and held read data.
// With RAM_ARB_RANGE_CHECK_EN defined, out-of-map accesses flag err and read back zero.
module ram_arb_resp #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             gnt_i,
    input  logic             we_i,
`ifdef RAM_ARB_RANGE_CHECK_EN
    input  logic             oob_i,
    output logic             err_o,
`endif
    input  logic [WIDTH-1:0] rdata_i,
    output logic             rvalid_o,
    output logic [WIDTH-1:0] rdata_o
);

    logic             rvalid_q;
    logic [WIDTH-1:0] rdata_q;
    logic [WIDTH-1:0] rdata_d;
`ifdef RAM_ARB_RANGE_CHECK_EN
    logic             err_q;
`endif

    always_comb begin
        rdata_d = rdata_q;
        if (gnt_i && !we_i) begin
            rdata_d = rdata_i;
`ifdef RAM_ARB_RANGE_CHECK_EN
            if (oob_i) begin
                rdata_d = '0;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
`ifdef RAM_ARB_RANGE_CHECK_EN
            err_q    <= 1'b0;
`endif
        end else begin
            rvalid_q <= gnt_i;
            rdata_q  <= rdata_d;
`ifdef RAM_ARB_RANGE_CHECK_EN
            err_q    <= gnt_i & oob_i;
`endif
        end
    end

    // A response still pending when reset arrives is dropped immediately.
    assign rvalid_o = rvalid_q & ~rst;
    assign rdata_o  = rdata_q;
`ifdef RAM_ARB_RANGE_CHECK_EN
    assign err_o    = err_q & ~rst;
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Two-master arbiter (core LSU = m0, JPEG DMA = m1) for the single-port data RAM,
// with a starvation counter bounding m1's wait. Optional macro: RAM_ARB_RANGE_CHECK_EN.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    ram_arbiter_if.slave     m0,
    ram_arbiter_if.slave     m1,
    output logic [WIDTH-1:0] ram_address,
    output logic [WIDTH-1:0] ram_wdata,
    output logic             ram_enw,
    input  logic [WIDTH-1:0] ram_rdata
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

    arb_state_t              state_q;
    arb_state_t              state_d;
    logic [STARVE_CNT_W-1:0] cnt_q;
    logic [STARVE_CNT_W-1:0] cnt_d;
    logic                    gnt0;
    logic                    gnt1;
    logic                    oob0;
    logic                    oob1;

`ifdef RAM_ARB_RANGE_CHECK_EN
    assign oob0 = addr_out_of_map(32'(m0.addr));
    assign oob1 = addr_out_of_map(32'(m1.addr));
`else
    assign oob0 = 1'b0;
    assign oob1 = 1'b0;
`endif

    always_comb begin
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        state_d = state_q;
        cnt_d   = cnt_q;

        if (!rst) begin
            unique case (state_q)
                PRIO_M0: begin
                    if (m0.req)      gnt0 = 1'b1;
                    else if (m1.req) gnt1 = 1'b1;
                end
                PRIO_M1: begin
                    if (m1.req)      gnt1 = 1'b1;
                    else if (m0.req) gnt0 = 1'b1;
                end
                default: ;
            endcase
        end

        unique case (state_q)
            PRIO_M0: if (cnt_q == LIMIT && !gnt1) state_d = PRIO_M1;
            PRIO_M1: if (gnt0 || gnt1)            state_d = PRIO_M0;
            default: state_d = PRIO_M0;
        endcase

        // The counter is consumed by the hand-off to PRIO_M1, so it restarts there.
        if (!m1.req || gnt1) begin
            cnt_d = '0;
        end else if (state_q == PRIO_M0 && cnt_q == LIMIT) begin
            cnt_d = '0;
        end else if (cnt_q != LIMIT) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PRIO_M0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        ram_address = '0;
        ram_wdata   = '0;
        ram_enw     = 1'b0;
        if (gnt0) begin
            ram_address = m0.addr;
            ram_wdata   = m0.wdata;
            ram_enw     = m0.we & ~oob0;
        end else if (gnt1) begin
            ram_address = m1.addr;
            ram_wdata   = m1.wdata;
            ram_enw     = m1.we & ~oob1;
        end
    end

    assign m0.gnt = gnt0;
    assign m1.gnt = gnt1;

    ram_arb_resp #(.WIDTH(WIDTH)) u_resp_m0 (
        .clk      (clk),
        .rst      (rst),
        .gnt_i    (gnt0),
        .we_i     (m0.we),
`ifdef RAM_ARB_RANGE_CHECK_EN
        .oob_i    (oob0),
        .err_o    (m0.err),
`endif
        .rdata_i  (ram_rdata),
        .rvalid_o (m0.rvalid),
        .rdata_o  (m0.rdata)
    );

    ram_arb_resp #(.WIDTH(WIDTH)) u_resp_m1 (
        .clk      (clk),
        .rst      (rst),
        .gnt_i    (gnt1),
        .we_i     (m1.we),
`ifdef RAM_ARB_RANGE_CHECK_EN
        .oob_i    (oob1),
        .err_o    (m1.err),
`endif
        .rdata_i  (ram_rdata),
        .rvalid_o (m1.rvalid),
        .rdata_o  (m1.rdata)
    );

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter with a behavioural RAM (unwritten words read 0xF000_0000|addr).
module tb_ram_arbiter;
    import ram_arb_pkg::*;

    localparam int WIDTH = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ram_address;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        ram_enw;

    bit [31:0] mem [4096];
    bit        wr  [4096];

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    ram_arbiter_if #(.WIDTH(WIDTH)) m0_if ();
    ram_arbiter_if #(.WIDTH(WIDTH)) m1_if ();

    ram_arbiter #(.WIDTH(WIDTH), .STARVE_LIMIT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .m0          (m0_if),
        .m1          (m1_if),
        .ram_address (ram_address),
        .ram_wdata   (ram_wdata),
        .ram_enw     (ram_enw),
        .ram_rdata   (ram_rdata)
    );

    assign ram_rdata = wr[ram_address[11:0]] ? mem[ram_address[11:0]]
                                             : (32'hF000_0000 | {20'h0, ram_address[11:0]});

    always @(posedge clk) begin
        if (ram_enw) begin
            mem[ram_address[11:0]] <= ram_wdata;
            wr[ram_address[11:0]]  <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        m0_if.req = req; m0_if.we = we; m0_if.addr = addr; m0_if.wdata = wdata;
    endtask

    task automatic drive1(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        m1_if.req = req; m1_if.we = we; m1_if.addr = addr; m1_if.wdata = wdata;
    endtask

    initial begin
        logic exp1;

        // Reset held two cycles with both masters requesting.
        rst = 1'b1;
        drive0(1'b1, 1'b0, 32'd10, 32'h0);
        drive1(1'b1, 1'b0, 32'd20, 32'h0);
        tick(); #1;
        check("rst_m0_gnt", 32'(m0_if.gnt), 32'd0);
        check("rst_m1_gnt", 32'(m1_if.gnt), 32'd0);
        check("rst_enw",    32'(ram_enw),   32'd0);
        tick(); #1;
        check("rst_m0_rvalid", 32'(m0_if.rvalid), 32'd0);
        check("rst_m1_rvalid", 32'(m1_if.rvalid), 32'd0);
        check("rst_m0_rdata",  m0_if.rdata, 32'd0);
        check("rst_m1_rdata",  m1_if.rdata, 32'd0);
        rst = 1'b0; #1;
        check("rel_m0_gnt",  32'(m0_if.gnt), 32'd1);
        check("rel_m1_gnt",  32'(m1_if.gnt), 32'd0);
        check("rel_ram_adr", ram_address, 32'd10);
        tick();
        drive0(1'b0, 1'b0, 32'd0, 32'h0);
        drive1(1'b0, 1'b0, 32'd0, 32'h0);
        #1;
        check("rel_m0_rvalid", 32'(m0_if.rvalid), 32'd1);
        check("rel_m0_rdata",  m0_if.rdata, 32'hF000_000A);
        check("rel_m1_rvalid", 32'(m1_if.rvalid), 32'd0);

        // Single master: m1 writes then reads back 1300.
        drive1(1'b1, 1'b1, 32'd1300, 32'hDEAD); #1;
        check("m1wr_gnt",   32'(m1_if.gnt), 32'd1);
        check("m1wr_enw",   32'(ram_enw),   32'd1);
        check("m1wr_addr",  ram_address, 32'd1300);
        check("m1wr_wdata", ram_wdata,   32'hDEAD);
        tick();
        drive1(1'b1, 1'b0, 32'd1300, 32'h0); #1;
        check("m1rd_gnt",      32'(m1_if.gnt),    32'd1);
        check("m1rd_enw",      32'(ram_enw),      32'd0);
        check("m1wr_ack",      32'(m1_if.rvalid), 32'd1);
        check("m1wr_ack_data", m1_if.rdata,       32'd0);
        check("m1wr_m0_rv",    32'(m0_if.rvalid), 32'd0);
        tick();
        drive1(1'b0, 1'b0, 32'd0, 32'h0); #1;
        check("m1rd_rvalid", 32'(m1_if.rvalid), 32'd1);
        check("m1rd_rdata",  m1_if.rdata,       32'hDEAD);
        check("m1rd_m0_rv",  32'(m0_if.rvalid), 32'd0);
        tick(); #1;
        check("m1_idle_rvalid", 32'(m1_if.rvalid), 32'd0);

        // Contention with STARVE_LIMIT=4: m0 x5, m1 x1, repeating every six cycles.
        drive0(1'b1, 1'b0, 32'd5, 32'h0);
        drive1(1'b1, 1'b0, 32'd6, 32'h0);
        for (int c = 0; c < 12; c++) begin
            #1;
            exp1 = ((c % 6) == 5);
            check($sformatf("cont_m0_gnt[%0d]", c), 32'(m0_if.gnt), 32'(!exp1));
            check($sformatf("cont_m1_gnt[%0d]", c), 32'(m1_if.gnt), 32'(exp1));
            check($sformatf("cont_cnt[%0d]", c),    32'(dut.cnt_q),   exp1 ? 32'd0 : 32'(c % 6));
            check($sformatf("cont_state[%0d]", c),  32'(dut.state_q), exp1 ? 32'd1 : 32'd0);
            tick();
        end
        drive0(1'b0, 1'b0, 32'd0, 32'h0);
        drive1(1'b0, 1'b0, 32'd0, 32'h0);

        // Cross-master coherency at 2500.
        drive0(1'b1, 1'b1, 32'd2500, 32'h1234); #1;
        check("coh_m0_gnt", 32'(m0_if.gnt), 32'd1);
        check("coh_enw",    32'(ram_enw),   32'd1);
        tick();
        drive0(1'b0, 1'b0, 32'd0, 32'h0);
        drive1(1'b1, 1'b0, 32'd2500, 32'h0); #1;
        check("coh_m1_gnt", 32'(m1_if.gnt), 32'd1);
        tick();
        drive1(1'b0, 1'b0, 32'd0, 32'h0); #1;
        check("coh_m1_rvalid", 32'(m1_if.rvalid), 32'd1);
        check("coh_m1_rdata",  m1_if.rdata,       32'h1234);

        // Reset while an m0 read response is pending and m1 is starving.
        tick();
        drive0(1'b1, 1'b0, 32'd10, 32'h0);
        drive1(1'b1, 1'b0, 32'd20, 32'h0); #1;
        check("mrst_m0_gnt", 32'(m0_if.gnt), 32'd1);
        tick();
        rst = 1'b1;
        drive0(1'b0, 1'b0, 32'd0, 32'h0); #1;
        check("mrst_cnt_before", 32'(dut.cnt_q),   32'd1);
        check("mrst_m0_rvalid",  32'(m0_if.rvalid), 32'd0);
        check("mrst_m1_gnt",     32'(m1_if.gnt),    32'd0);
        tick();
        rst = 1'b0;
        drive1(1'b0, 1'b0, 32'd0, 32'h0); #1;
        check("mrst_rvalid_after", 32'(m0_if.rvalid), 32'd0);
        check("mrst_rdata_after",  m0_if.rdata,       32'd0);
        check("mrst_state",        32'(dut.state_q),  32'd0);
        check("mrst_cnt",          32'(dut.cnt_q),    32'd0);

`ifdef RAM_ARB_RANGE_CHECK_EN
        // Range check: 1536 is the last mapped block word, 1800 is in the hole.
        tick();
        drive0(1'b1, 1'b0, 32'd1536, 32'h0); #1;
        check("rc_1536_gnt", 32'(m0_if.gnt), 32'd1);
        tick();
        drive0(1'b1, 1'b1, 32'd1800, 32'h5555); #1;
        check("rc_wr_gnt",     32'(m0_if.gnt),    32'd1);
        check("rc_wr_enw",     32'(ram_enw),      32'd0);
        check("rc_1536_rv",    32'(m0_if.rvalid), 32'd1);
        check("rc_1536_err",   32'(m0_if.err),    32'd0);
        check("rc_1536_rdata", m0_if.rdata,       32'hF000_0600);
        tick();
        drive0(1'b1, 1'b0, 32'd1800, 32'h0); #1;
        check("rc_wr_ack_rv",  32'(m0_if.rvalid), 32'd1);
        check("rc_wr_ack_err", 32'(m0_if.err),    32'd1);
        check("rc_wr_nocommit", 32'(wr[1800]),    32'd0);
        tick();
        drive0(1'b0, 1'b0, 32'd0, 32'h0); #1;
        check("rc_rd_rv",    32'(m0_if.rvalid), 32'd1);
        check("rc_rd_err",   32'(m0_if.err),    32'd1);
        check("rc_rd_rdata", m0_if.rdata,       32'd0);
        tick(); #1;
        check("rc_err_pulse", 32'(m0_if.err), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
